// File: rtl/fft16_reorder_if.sv
// fft16_reorder_if: two-lane bit-reversed input beats and natural-order output beats of the reorder buffer
interface fft16_reorder_if #(parameter int width = 8);
  logic             valid_i;
  logic [width-1:0] ar, ai, br, bi;
  logic             valid_o;
  logic [width-1:0] xr, xi, yr, yi;
  logic [2:0]       index_o;
  logic             sof_o, eof_o, overrun;
  modport master (output valid_i, ar, ai, br, bi,
                  input  valid_o, xr, xi, yr, yi, index_o, sof_o, eof_o, overrun);
  modport slave  (input  valid_i, ar, ai, br, bi,
                  output valid_o, xr, xi, yr, yi, index_o, sof_o, eof_o, overrun);
endinterface

// File: rtl/fft16_reorder.sv
// fft16_reorder: ping-pong reorder buffer turning the 16-point FFT's bit-reversed two-lane stream into natural order
module fft16_reorder #(parameter int width = 8) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           ce,
  input  logic           clear,
  fft16_reorder_if.slave io
);
  typedef enum logic {IDLE, READ} state_t;
  state_t           state_q, state_d;
  logic [width-1:0] re_q [2][16];
  logic [width-1:0] im_q [2][16];
  logic [2:0]       wr_cnt_q, rd_cnt_q, index_q;
  logic             wr_bank_q, rd_bank_q;
  logic [1:0]       full_q, full_d;
  logic             wr_en, wr_last, issue, rd_last;
  logic [width-1:0] xr_q, xi_q, yr_q, yi_q;
  logic             valid_q, sof_q, eof_q, overrun_q;
  logic [3:0]       wa, wb, ra, rb;
  assign wa = {1'b0, wr_cnt_q[0], wr_cnt_q[1], wr_cnt_q[2]};
  assign wb = {1'b1, wr_cnt_q[0], wr_cnt_q[1], wr_cnt_q[2]};
  assign ra = {rd_cnt_q, 1'b0};
  assign rb = {rd_cnt_q, 1'b1};
  assign wr_en   = ce & io.valid_i & ~clear;
  assign wr_last = wr_en & (wr_cnt_q == 3'd7);
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) state_q <= IDLE;
    else if (clear) state_q <= IDLE;
    else if (ce) state_q <= state_d;
  // a frame completing into the other bank this cycle must keep READ going without a gap
  always_comb begin
    state_d = (state_q == IDLE) ? (full_q[rd_bank_q] ? READ : IDLE)
            : ((rd_cnt_q != 3'd7) || full_q[~rd_bank_q] || (wr_last && (wr_bank_q != rd_bank_q))) ? READ : IDLE;
  end
  always_comb begin
    issue   = ce & ~clear & ((state_q == READ) | full_q[rd_bank_q]);
    rd_last = issue & (rd_cnt_q == 3'd7);
    full_d  = full_q;
    if (rd_last) full_d[rd_bank_q] = 1'b0;
    if (wr_last) full_d[wr_bank_q] = 1'b1;
  end
  always_ff @(posedge CLK)
    if (wr_en) begin
      re_q[wr_bank_q][wa] <= io.ar;
      im_q[wr_bank_q][wa] <= io.ai;
      re_q[wr_bank_q][wb] <= io.br;
      im_q[wr_bank_q][wb] <= io.bi;
    end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= '0;
      valid_q   <= 1'b0;
      sof_q     <= 1'b0;
      eof_q     <= 1'b0;
      overrun_q <= 1'b0;
      index_q   <= '0;
      xr_q      <= '0;
      xi_q      <= '0;
      yr_q      <= '0;
      yi_q      <= '0;
    end else if (clear) begin
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= '0;
      valid_q   <= 1'b0;
      sof_q     <= 1'b0;
      eof_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else if (ce) begin
      full_q  <= full_d;
      valid_q <= issue;
      sof_q   <= issue & (rd_cnt_q == 3'd0);
      eof_q   <= rd_last;
      if (io.valid_i) begin
        wr_cnt_q  <= wr_cnt_q + 3'd1;
        wr_bank_q <= wr_bank_q ^ (wr_cnt_q == 3'd7);
        if ((wr_cnt_q == 3'd0) && full_q[wr_bank_q]) overrun_q <= 1'b1;
      end
      if (issue) begin
        rd_cnt_q  <= rd_cnt_q + 3'd1;
        rd_bank_q <= rd_bank_q ^ rd_last;
        index_q   <= rd_cnt_q;
        xr_q      <= re_q[rd_bank_q][ra];
        xi_q      <= im_q[rd_bank_q][ra];
        yr_q      <= re_q[rd_bank_q][rb];
        yi_q      <= im_q[rd_bank_q][rb];
      end
    end
  assign io.valid_o = valid_q;
  assign io.xr      = xr_q;
  assign io.xi      = xi_q;
  assign io.yr      = yr_q;
  assign io.yi      = yi_q;
  assign io.index_o = index_q;
  assign io.sof_o   = sof_q;
  assign io.eof_o   = eof_q;
  assign io.overrun = overrun_q;
endmodule

// File: tb/tb_fft16_reorder.sv
// tb_fft16_reorder: directed frames with a scoreboard queue popped by an output monitor
module tb_fft16_reorder;
  logic CLK = 1'b0, RST_N = 1'b0, ce = 1'b0, clear = 1'b0;
  fft16_reorder_if #(.width(8)) io();
  fft16_reorder #(.width(8)) dut (.CLK(CLK), .RST_N(RST_N), .ce(ce), .clear(clear), .io(io));
  always #5 CLK = ~CLK;
  int cyc = 0, n_checks = 0, n_fail = 0, nbeats = 0;
  int first_cyc = 0, last_cyc = 0, sof_cyc = 0, eof_cyc = 0, at = 0;
  logic ce_prev = 1'b0;
  bit ce_mode = 0, freeze_chk = 0;
  logic [36:0] sb [$];
  logic [38:0] snap = '0;
  always @(posedge CLK) begin
    cyc     <= cyc + 1;
    ce_prev <= ce;
  end
  function automatic logic [36:0] outs();
    return {io.xr, io.xi, io.yr, io.yi, io.index_o, io.sof_o, io.eof_o};
  endfunction
  function automatic logic [2:0] br3(input logic [2:0] v);
    return {v[0], v[1], v[2]};
  endfunction
  always @(negedge CLK) begin
    logic [36:0] e;
    if (RST_N && ce_prev && io.valid_o) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL beat_unexpected: got %h, no beat required", outs());
      end else begin
        e = sb.pop_front();
        if (outs() !== e) begin
          n_fail++;
          $display("FAIL beat_data: got %h, required %h", outs(), e);
        end
      end
      nbeats++;
      if (nbeats == 1) first_cyc = cyc;
      last_cyc = cyc;
      if (io.sof_o) sof_cyc = cyc;
      if (io.eof_o) eof_cyc = cyc;
    end
    if (freeze_chk && !ce_prev) begin
      n_checks++;
      if ({io.valid_o, io.overrun, outs()} !== snap) begin
        n_fail++;
        $display("FAIL freeze: got %h, required %h", {io.valid_o, io.overrun, outs()}, snap);
      end
    end
    snap = {io.valid_o, io.overrun, outs()};
  end
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask
  task automatic step();
    @(posedge CLK);
    #1;
    if (ce_mode) ce = ~ce;
  endtask
  task automatic beat(input logic [7:0] a, input logic [7:0] b, output int t);
    bit was;
    io.ar = a;
    io.ai = -a;
    io.br = b;
    io.bi = -b;
    io.valid_i = 1'b1;
    do begin
      t = cyc;
      was = ce;
      step();
    end while (!was);
    io.valid_i = 1'b0;
  endtask
  task automatic push(input int f, input int m);
    logic [7:0] x, y, nx, ny;
    x  = 8'(2 * m + 16 * f);
    y  = x + 8'd1;
    nx = -x;
    ny = -y;
    sb.push_back({x, nx, y, ny, 3'(m), m == 0, m == 7});
  endtask
  task automatic frame(input int f, input int nb, input int np, input int gap, output int t);
    logic [7:0] a;
    for (int m = 0; m < np; m++) push(f, m);
    for (int k = 0; k < nb; k++) begin
      a = {5'b0, br3(3'(k))} + 8'(16 * f);
      beat(a, a + 8'd8, t);
      if (gap > 0) repeat ((k % gap) + 1) step();
    end
  endtask
  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      step();
      t++;
    end
    check("drain_queue_empty", 64'(sb.size()), 0);
    repeat (2) step();
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int t;
    io.valid_i = 1'b0;
    io.ar = '0;
    io.ai = '0;
    io.br = '0;
    io.bi = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_outputs", {io.valid_o, io.overrun, outs()}, 0);
    RST_N = 1'b1;
    ce = 1'b1;
    step();
    nbeats = 0;
    frame(0, 8, 8, 0, at);
    drain();
    check("latency_first", 64'(sof_cyc), 64'(at + 2));
    check("latency_last", 64'(eof_cyc), 64'(at + 9));
    check("single_frame_beats", 64'(nbeats), 8);
    nbeats = 0;
    for (int f = 1; f <= 4; f++) frame(f, 8, 8, 0, at);
    drain();
    check("b2b_beats", 64'(nbeats), 32);
    check("b2b_contiguous", 64'(last_cyc - first_cyc), 31);
    check("b2b_overrun", io.overrun, 0);
    ce_mode = 1;
    freeze_chk = 1;
    frame(5, 8, 8, 3, at);
    drain();
    ce_mode = 0;
    freeze_chk = 0;
    ce = 1'b1;
    step();
    frame(6, 5, 0, 0, at);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clear_valid", io.valid_o, 0);
    check("clear_overrun", io.overrun, 0);
    nbeats = 0;
    frame(7, 8, 8, 0, at);
    drain();
    check("after_clear_beats", 64'(nbeats), 8);
    frame(8, 8, 3, 0, at);
    t = 0;
    while (!(io.valid_o && io.index_o == 3'd3) && t < 40) begin
      step();
      t++;
    end
    check("reach_m3", 64'(t < 40), 1);
    #2;
    RST_N = 1'b0;
    #1;
    check("async_reset_outputs", {io.valid_o, io.overrun, outs()}, 0);
    repeat (2) step();
    RST_N = 1'b1;
    check("after_reset_queue", 64'(sb.size()), 0);
    frame(9, 8, 8, 0, at);
    drain();
    check("final_overrun", io.overrun, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
